// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - right-to-left square-and-multiply modexp controller driving an external modulo reducer
// Optional feature: define MODEXP_OPCOUNT_EN to add the op_count output.
module modexp_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     base,
    input  logic [DATA_WIDTH-1:0]     exponent,
    input  logic [DATA_WIDTH-1:0]     modulus,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      done,
    output logic                      busy,
    output logic                      mod_start,
    output logic [2*DATA_WIDTH-1:0]   mod_a,
    output logic [2*DATA_WIDTH-1:0]   mod_m,
    input  logic [2*DATA_WIDTH-1:0]   mod_out,
    input  logic                      mod_done
`ifdef MODEXP_OPCOUNT_EN
    ,
    output logic [7:0]                op_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ISSUE, S_WAIT, S_STEP, S_DONE} state_t;
    typedef enum logic [1:0] {OP_RED_BASE, OP_MUL, OP_SQR} op_t;

    state_t state, state_nx;
    op_t    op;

    logic [DATA_WIDTH-1:0]   acc, b, e, mod_q;
    logic                    wait_first;
    logic                    accept;
    logic                    latch;
    logic                    step_mul;
    logic                    step_finish;
    logic [2*DATA_WIDTH-1:0] acc_x, b_x;
    logic                    unused_mod_out_hi;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    // The reducer's done is still high from the previous op during the first WAIT cycle.
    assign latch     = (state == S_WAIT) && !wait_first && mod_done;
    assign step_mul  = e[0] && (op != OP_MUL);
    assign step_finish = (e == '0) || (!step_mul && (e[DATA_WIDTH-1:1] == '0));

    assign acc_x = {{DATA_WIDTH{1'b0}}, acc};
    assign b_x   = {{DATA_WIDTH{1'b0}}, b};
    assign mod_m = {{DATA_WIDTH{1'b0}}, mod_q};
    assign unused_mod_out_hi = |mod_out[2*DATA_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mod_start = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_INIT;
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_INIT;
            end
            S_INIT: begin
                busy     = 1'b1;
                state_nx = (mod_q <= 1) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy      = 1'b1;
                mod_start = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (latch) state_nx = S_STEP;
            end
            S_STEP: begin
                busy     = 1'b1;
                state_nx = step_finish ? S_DONE : S_ISSUE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            b          <= '0;
            e          <= '0;
            mod_q      <= '0;
            op         <= OP_RED_BASE;
            mod_a      <= '0;
            result     <= '0;
            wait_first <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        b     <= base;
                        e     <= exponent;
                        mod_q <= modulus;
                    end
                end
                S_INIT: begin
                    if (mod_q <= 1) begin
                        result <= '0;
                    end else begin
                        acc   <= 1;
                        op    <= OP_RED_BASE;
                        mod_a <= b_x;
                    end
                end
                S_ISSUE: wait_first <= 1'b1;
                S_WAIT: begin
                    wait_first <= 1'b0;
                    if (latch) begin
                        case (op)
                            OP_MUL: acc <= mod_out[DATA_WIDTH-1:0];
                            OP_SQR: begin
                                b <= mod_out[DATA_WIDTH-1:0];
                                e <= e >> 1;
                            end
                            default: b <= mod_out[DATA_WIDTH-1:0];
                        endcase
                    end
                end
                S_STEP: begin
                    if (step_finish) begin
                        result <= acc;
                    end else if (step_mul) begin
                        op    <= OP_MUL;
                        mod_a <= acc_x * b_x;
                    end else begin
                        op    <= OP_SQR;
                        mod_a <= b_x * b_x;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MODEXP_OPCOUNT_EN
    always_ff @(posedge clk) begin
        if (reset || accept)
            op_count <= '0;
        else if (mod_start && op_count != 8'hFF)
            op_count <= op_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - directed self-checking bench for modexp_ctrl with a stale-done reducer model
module tb_modexp_ctrl;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   base = '0, exponent = '0, modulus = '0;
    logic [W-1:0]   result;
    logic           done, busy, mod_start;
    logic [2*W-1:0] mod_a, mod_m;
    logic [2*W-1:0] mod_out = 16'hBEEF;
    logic           mod_done = 1'b1;
`ifdef MODEXP_OPCOUNT_EN
    logic [7:0]     op_count;
`endif

    int total = 0;
    int bad = 0;
    int red_lat = 3;

    always #5 clk = ~clk;

    modexp_ctrl #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base(base), .exponent(exponent), .modulus(modulus),
        .result(result), .done(done), .busy(busy),
        .mod_start(mod_start), .mod_a(mod_a), .mod_m(mod_m),
        .mod_out(mod_out), .mod_done(mod_done)
`ifdef MODEXP_OPCOUNT_EN
        , .op_count(op_count)
`endif
    );

    // Reducer model: samples mod_start one cycle late, so done stays stale-high in the first WAIT cycle.
    logic           start_seen = 1'b0;
    logic [2*W-1:0] red_a = '0;
    int             red_cnt = 0;
    always @(posedge clk) begin
        start_seen <= mod_start;
        if (start_seen) begin
            red_a    <= mod_a;
            red_cnt  <= red_lat;
            mod_done <= 1'b0;
        end else if (red_cnt > 0) begin
            red_cnt <= red_cnt - 1;
            if (red_cnt == 1) begin
                mod_done <= 1'b1;
                mod_out  <= red_a % mod_m;
            end
        end
    end

    int             n_pulse = 0;
    logic [2*W-1:0] a_log [0:4095];
    always @(posedge clk) begin
        if (mod_start) begin
            a_log[n_pulse % 4096] <= mod_a;
            n_pulse <= n_pulse + 1;
        end
    end

    task automatic kick(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          output int pulses, output int p_first, output int cycles);
        p_first = n_pulse;
        kick(b, e, m);
        wait_done(cycles);
        pulses = n_pulse - p_first;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL reset_result: got %0d expected 0", result); end
        total++; if (mod_start !== 1'b0) begin bad++; $display("FAIL reset_mod_start: got %b expected 0", mod_start); end
    endtask

    task automatic test_basic();
        int pulses, p0, cyc;
        red_lat = 3;
        run_op(8'd3, 8'd5, 8'd7, pulses, p0, cyc);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b expected 1", done); end
        total++; if (result !== 8'd5) begin bad++; $display("FAIL basic_result: got %0d expected 5", result); end
        total++; if (pulses != 5) begin bad++; $display("FAIL basic_pulses: got %0d expected 5", pulses); end
        total++; if (mod_m !== 16'd7) begin bad++; $display("FAIL basic_mod_m: got %0d expected 7", mod_m); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b expected 0", busy); end
`ifdef MODEXP_OPCOUNT_EN
        total++; if (op_count !== 8'd5) begin bad++; $display("FAIL basic_op_count: got %0d expected 5", op_count); end
`endif
    endtask

    task automatic test_vectors();
        int pulses, p0, cyc;
        red_lat = 1;
        run_op(8'd2, 8'd10, 8'd255, pulses, p0, cyc);
        total++; if (result !== 8'd4) begin bad++; $display("FAIL vec_2_10_255: got %0d expected 4", result); end
        total++; if (pulses != 6) begin bad++; $display("FAIL vec_2_10_255_pulses: got %0d expected 6", pulses); end
        run_op(8'd200, 8'd2, 8'd251, pulses, p0, cyc);
        total++; if (result !== 8'd91) begin bad++; $display("FAIL vec_200_2_251: got %0d expected 91", result); end
        total++; if (a_log[(p0 + 1) % 4096] !== 16'd40000) begin bad++; $display("FAIL vec_square_mod_a: got %0d expected 40000", a_log[(p0 + 1) % 4096]); end
        red_lat = 2;
        run_op(8'd250, 8'd3, 8'd7, pulses, p0, cyc);
        total++; if (a_log[p0 % 4096] !== 16'd250) begin bad++; $display("FAIL vec_first_mod_a: got %0d expected 250", a_log[p0 % 4096]); end
        total++; if (a_log[(p0 + 1) % 4096] !== 16'd5) begin bad++; $display("FAIL vec_reduced_base: got %0d expected 5", a_log[(p0 + 1) % 4096]); end
        total++; if (result !== 8'd6) begin bad++; $display("FAIL vec_250_3_7: got %0d expected 6", result); end
        total++; if (pulses != 4) begin bad++; $display("FAIL vec_250_3_7_pulses: got %0d expected 4", pulses); end
        run_op(8'd9, 8'd0, 8'd13, pulses, p0, cyc);
        total++; if (result !== 8'd1) begin bad++; $display("FAIL vec_exp0: got %0d expected 1", result); end
        total++; if (pulses != 1) begin bad++; $display("FAIL vec_exp0_pulses: got %0d expected 1", pulses); end
        run_op(8'd5, 8'd3, 8'd1, pulses, p0, cyc);
        total++; if (result !== 8'd0 || done !== 1'b1) begin bad++; $display("FAIL vec_mod1: got result=%0d done=%b expected 0/1", result, done); end
        total++; if (pulses != 0) begin bad++; $display("FAIL vec_mod1_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_mod_zero();
        int pulses, p0, cyc;
        red_lat = 2;
        run_op(8'd3, 8'd5, 8'd7, pulses, p0, cyc);
        run_op(8'd4, 8'd4, 8'd0, pulses, p0, cyc);
        total++; if (cyc > 1 || done !== 1'b1) begin bad++; $display("FAIL mod0_latency: got %0d cycles done=%b expected <=1 and 1", cyc, done); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL mod0_result: got %0d expected 0", result); end
        total++; if (pulses != 0) begin bad++; $display("FAIL mod0_pulses: got %0d expected 0", pulses); end
        p0 = n_pulse;
        kick(8'd6, 8'd2, 8'd0);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mod0_restart_clears_done: got %b expected 0", done); end
        wait_done(cyc);
        total++; if (done !== 1'b1 || result !== 8'd0 || n_pulse != p0) begin bad++; $display("FAIL mod0_repeat: got done=%b result=%0d pulses=%0d expected 1/0/0", done, result, n_pulse - p0); end
`ifdef MODEXP_OPCOUNT_EN
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL mod0_op_count: got %0d expected 0", op_count); end
`endif
    endtask

    task automatic test_start_ignored();
        int p0, cyc;
        red_lat = 2;
        p0 = n_pulse;
        kick(8'd3, 8'd5, 8'd7);
        repeat (4) @(negedge clk);
        base = 8'd2; exponent = 8'd10; modulus = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignored_busy: got %b expected 1", busy); end
        wait_done(cyc);
        total++; if (result !== 8'd5) begin bad++; $display("FAIL ignored_result: got %0d expected 5", result); end
        total++; if (n_pulse - p0 != 5) begin bad++; $display("FAIL ignored_pulses: got %0d expected 5", n_pulse - p0); end
        total++; if (mod_m !== 16'd7) begin bad++; $display("FAIL ignored_mod_m: got %0d expected 7", mod_m); end
    endtask

    task automatic test_reset_mid();
        int c, pulses, p0, cyc;
        red_lat = 4;
        kick(8'd3, 8'd5, 8'd7);
        c = 0;
        while (!mod_start && c < 100) begin
            @(negedge clk);
            c++;
        end
        total++; if (mod_start !== 1'b1) begin bad++; $display("FAIL midreset_issue_seen: got %b expected 1", mod_start); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_flags: got done=%b busy=%b expected 0/0", done, busy); end
        total++; if (result !== 8'd0) begin bad++; $display("FAIL midreset_result: got %0d expected 0", result); end
        total++; if (mod_start !== 1'b0 || mod_a !== 16'd0) begin bad++; $display("FAIL midreset_mod: got mod_start=%b mod_a=%0d expected 0/0", mod_start, mod_a); end
        run_op(8'd2, 8'd10, 8'd255, pulses, p0, cyc);
        total++; if (result !== 8'd4 || done !== 1'b1) begin bad++; $display("FAIL midreset_rerun: got result=%0d done=%b expected 4/1", result, done); end
        total++; if (pulses != 6) begin bad++; $display("FAIL midreset_rerun_pulses: got %0d expected 6", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_mod_zero();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
